giaima_5421_word: RTL and testbench

//  Sequential 5421-code-to-BCD decoder; inverse of our BCD->5421 converter.

---
 rtl/giaima_5421_word.sv | 145 ++++++++++++++
 tb/tb_giaima_5421_word.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/giaima_5421_word.sv
// giaima_5421_word: sequential 5421-code -> BCD decoder. It takes one digit per handshake, MSD first,
//   and emits a per-digit BCD/ASCII pulse plus a packed word every DIGITS digits.
// Latency: dig_* 1 cycle after accept; out_valid rises in the same cycle as the last digit's dig_valid.
// Backpressure: in_ready drops while a finished word waits in HOLD for out_ready; clr/rst discard.
// Ports:
//   clk, rst (sync, active-high), clr (sync abort of the partial word)
//   in_valid/in_ready/in_code      : 5421 digit input handshake
//   dig_valid/dig_bcd/dig_ascii    : per-digit decoded result (registered pulse)
//   out_valid/out_ready/out_bcd/out_err_mask : packed word output handshake
module giaima_5421_word #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_code,
  output logic                  dig_valid,
  output logic [3:0]            dig_bcd,
  output logic [7:0]            dig_ascii,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_err_mask
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  typedef enum logic {S_COLLECT, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              dig_valid_q, dig_valid_d;
  logic [3:0]        dig_bcd_q, dig_bcd_d;
  logic [7:0]        dig_ascii_q, dig_ascii_d;
  logic [W-1:0]      out_bcd_q, out_bcd_d;
  logic [DIGITS-1:0] out_err_mask_q, out_err_mask_d;

  logic              code_err;
  logic [3:0]        code_bcd;
  logic              accept;
  logic [W-1:0]      shift_next;
  logic [DIGITS-1:0] mask_next;

  // A 5421 digit is valid only when its low three bits are 0..4; bit 3 carries weight 5.
  always_comb begin
    code_err = (in_code[2:0] > 3'd4);
    code_bcd = 4'd0;
    if (!code_err) begin
      code_bcd = in_code[3] ? ({1'b0, in_code[2:0]} + 4'd5) : {1'b0, in_code[2:0]};
    end
  end

  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;

  // Shifting left keeps the first (most significant) digit in the top nibble once the word is full.
  assign shift_next = (shift_q << 4) | W'(code_bcd);
  assign mask_next  = (mask_q << 1) | DIGITS'(code_err);

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    shift_d        = shift_q;
    mask_d         = mask_q;
    dig_valid_d    = 1'b0;
    dig_bcd_d      = dig_bcd_q;
    dig_ascii_d    = dig_ascii_q;
    out_bcd_d      = out_bcd_q;
    out_err_mask_d = out_err_mask_q;

    if (clr) begin
      // Abort drops any same-cycle digit; the last delivered word stays visible.
      state_d = S_COLLECT;
      count_d = '0;
      shift_d = '0;
      mask_d  = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (accept) begin
            dig_valid_d = 1'b1;
            dig_bcd_d   = code_bcd;
            dig_ascii_d = code_err ? 8'h3F : (8'h30 + {4'h0, code_bcd});
            if (count_q == LAST_CNT) begin
              out_bcd_d      = shift_next;
              out_err_mask_d = mask_next;
              shift_d        = '0;
              mask_d         = '0;
              count_d        = '0;
              state_d        = S_HOLD;
            end else begin
              shift_d = shift_next;
              mask_d  = mask_next;
              count_d = count_q + CW'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_COLLECT;
          end
        end
        default: state_d = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_COLLECT;
      count_q        <= '0;
      shift_q        <= '0;
      mask_q         <= '0;
      dig_valid_q    <= 1'b0;
      dig_bcd_q      <= 4'd0;
      dig_ascii_q    <= 8'h30;
      out_bcd_q      <= '0;
      out_err_mask_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      shift_q        <= shift_d;
      mask_q         <= mask_d;
      dig_valid_q    <= dig_valid_d;
      dig_bcd_q      <= dig_bcd_d;
      dig_ascii_q    <= dig_ascii_d;
      out_bcd_q      <= out_bcd_d;
      out_err_mask_q <= out_err_mask_d;
    end
  end

  assign dig_valid    = dig_valid_q;
  assign dig_bcd      = dig_bcd_q;
  assign dig_ascii    = dig_ascii_q;
  assign out_bcd      = out_bcd_q;
  assign out_err_mask = out_err_mask_q;

endmodule

// File: tb/tb_giaima_5421_word.sv
module tb_giaima_5421_word;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_valid, out_ready, dig_valid;
  logic [3:0]  in_code, dig_bcd;
  logic [7:0]  dig_ascii;
  logic [15:0] out_bcd;
  logic [3:0]  out_err_mask;

  int checks   = 0;
  int failures = 0;

  giaima_5421_word #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .dig_valid(dig_valid), .dig_bcd(dig_bcd), .dig_ascii(dig_ascii),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_err_mask(out_err_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [3:0] bcd;
    logic [7:0] ascii;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one digit, waiting (bounded) for in_ready first; leaves in_valid low afterwards.
  task automatic send(input logic [3:0] code);
    int n = 0;
    in_valid = 1'b0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_code  = code;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 4'd0, 8'h30};
    tbl[1]  = '{4'b0001, 4'd1, 8'h31};
    tbl[2]  = '{4'b0010, 4'd2, 8'h32};
    tbl[3]  = '{4'b0011, 4'd3, 8'h33};
    tbl[4]  = '{4'b0100, 4'd4, 8'h34};
    tbl[5]  = '{4'b0101, 4'd0, 8'h3F};
    tbl[6]  = '{4'b0110, 4'd0, 8'h3F};
    tbl[7]  = '{4'b0111, 4'd0, 8'h3F};
    tbl[8]  = '{4'b1000, 4'd5, 8'h35};
    tbl[9]  = '{4'b1001, 4'd6, 8'h36};
    tbl[10] = '{4'b1010, 4'd7, 8'h37};
    tbl[11] = '{4'b1011, 4'd8, 8'h38};
    tbl[12] = '{4'b1100, 4'd9, 8'h39};
    tbl[13] = '{4'b1101, 4'd0, 8'h3F};
    tbl[14] = '{4'b1110, 4'd0, 8'h3F};
    tbl[15] = '{4'b1111, 4'd0, 8'h3F};

    // T1: reset with in_valid asserted
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; in_code = 4'b0001; out_ready = 1'b1;
    tick(); tick();
    chk("t1_in_ready",  32'(in_ready),  32'd1);
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_out_bcd",   32'(out_bcd),   32'h0);
    chk("t1_dig_ascii", 32'(dig_ascii), 32'h30);
    chk("t1_dig_valid", 32'(dig_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0;

    // T2: every code, out_ready high so completed words drain
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].code);
      chk($sformatf("t2_dig_valid_%0d", i), 32'(dig_valid), 32'd1);
      chk($sformatf("t2_dig_bcd_%0d", i),   32'(dig_bcd),   32'(tbl[i].bcd));
      chk($sformatf("t2_dig_ascii_%0d", i), 32'(dig_ascii), 32'(tbl[i].ascii));
    end
    // last word of T2: codes 1100,1101,1110,1111
    chk("t2_word", 32'(out_bcd), 32'h9000);
    chk("t2_mask", 32'(out_err_mask), 32'h7);

    // T3: clean word with out_ready high
    send(4'b0001);
    chk("t3_hold_prev_bcd",  32'(out_bcd),      32'h9000);
    chk("t3_hold_prev_mask", 32'(out_err_mask), 32'h7);
    send(4'b1000);
    send(4'b0100);
    chk("t3_no_early_valid", 32'(out_valid), 32'd0);
    send(4'b1100);
    chk("t3_out_valid", 32'(out_valid),    32'd1);
    chk("t3_dig_valid", 32'(dig_valid),    32'd1);
    chk("t3_out_bcd",   32'(out_bcd),      32'h1549);
    chk("t3_mask",      32'(out_err_mask), 32'h0);
    chk("t3_in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    chk("t3_out_valid_drop", 32'(out_valid), 32'd0);
    chk("t3_in_ready_back",  32'(in_ready),  32'd1);

    // T4: error digits with backpressure
    out_ready = 1'b0;
    send(4'b0111); send(4'b0011); send(4'b1110); send(4'b1011);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_code = 4'b0001;
      tick();
      chk($sformatf("t4_out_valid_%0d", c), 32'(out_valid),    32'd1);
      chk($sformatf("t4_in_ready_%0d", c),  32'(in_ready),     32'd0);
      chk($sformatf("t4_out_bcd_%0d", c),   32'(out_bcd),      32'h0308);
      chk($sformatf("t4_mask_%0d", c),      32'(out_err_mask), 32'hA);
      chk($sformatf("t4_dig_quiet_%0d", c), 32'(dig_valid),    32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_handoff_valid", 32'(out_valid), 32'd0);
    chk("t4_handoff_nodig", 32'(dig_valid), 32'd0);
    chk("t4_handoff_ready", 32'(in_ready),  32'd1);
    in_valid = 1'b0;

    // T5: clr discards a partial word and a same-cycle digit
    send(4'b0001); send(4'b0010);
    clr = 1'b1; in_valid = 1'b1; in_code = 4'b0011;
    tick();
    chk("t5_clr_nodig",  32'(dig_valid), 32'd0);
    chk("t5_clr_ready",  32'(in_ready),  32'd1);
    chk("t5_clr_keep",   32'(out_bcd),   32'h0308);
    clr = 1'b0; in_valid = 1'b0;
    send(4'b1001); send(4'b0000); send(4'b0010);
    chk("t5_no_early_valid", 32'(out_valid), 32'd0);
    send(4'b1010);
    chk("t5_out_valid", 32'(out_valid),    32'd1);
    chk("t5_out_bcd",   32'(out_bcd),      32'h6027);
    chk("t5_mask",      32'(out_err_mask), 32'h0);

    // T6: reset while a word is pending
    send(4'b0000);
    chk("t6_prev_word", 32'(out_bcd), 32'h6027);
    out_ready = 1'b0;
    send(4'b0001); send(4'b0010); send(4'b0011);
    chk("t6_pending_valid", 32'(out_valid), 32'd1);
    chk("t6_pending_bcd",   32'(out_bcd),   32'h0123);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_out_valid", 32'(out_valid),    32'd0);
    chk("t6_rst_out_bcd",   32'(out_bcd),      32'h0);
    chk("t6_rst_mask",      32'(out_err_mask), 32'h0);
    chk("t6_rst_in_ready",  32'(in_ready),     32'd1);
    chk("t6_rst_ascii",     32'(dig_ascii),    32'h30);

    // after reset the count restarts: four fresh digits form a complete word
    out_ready = 1'b1;
    send(4'b1100); send(4'b1000); send(4'b0100);
    chk("t6_restart_no_valid", 32'(out_valid), 32'd0);
    send(4'b0000);
    chk("t6_restart_bcd", 32'(out_bcd), 32'h9540);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
